// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Posted-store buffer between the processor data-memory port and a slower
//   valid/ready data memory. Stores are accepted in one cycle and drained in
//   FIFO order. The processor is stalled only when the buffer is full. Loads
//   whose word address matches a buffered store receive the youngest
//   matching data.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, discards all pending stores
//   MemWrite   processor store strobe
//   DataAdr    processor byte address (store or load)
//   WriteData  processor store data
//   RdEn       processor load uses DataAdr this cycle
//   Stall      MemWrite while full (combinational)
//   FwdHit     load word address matches a buffered entry (combinational)
//   FwdData    data of the youngest matching entry, 0 when no hit
//   mem_valid  head entry presented to memory
//   mem_addr   head entry address
//   mem_wdata  head entry data
//   mem_ready  memory accepts the head entry this cycle
//   count      number of valid entries
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [AW-1:0]            DataAdr,
  input  logic [DW-1:0]            WriteData,
  input  logic                     RdEn,
  output logic                     Stall,
  output logic                     FwdHit,
  output logic [DW-1:0]            FwdData,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [DW-1:0] w_fdata;
  logic [PW-1:0] w_idx;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Push is gated on the registered full flag, so a slot freed by a pop
  // this cycle is only usable at the following edge.
  assign w_push  = MemWrite && !w_full;
  assign w_pop   = !w_empty && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents need no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= DataAdr;
      r_data[r_tail] <= WriteData;
    end
  end

  // Walk entries from oldest to youngest so the last match seen is the
  // youngest. Only slots within count of head are live; an entry being
  // popped this cycle is still live here.
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (RdEn && (CW'(i) < r_count) &&
          (r_addr[w_idx][AW-1:2] == DataAdr[AW-1:2])) begin
        w_hit   = 1'b1;
        w_fdata = r_data[w_idx];
      end
    end
  end

  assign Stall     = MemWrite && w_full;
  assign FwdHit    = w_hit;
  assign FwdData   = w_fdata;
  assign mem_valid = !w_empty;
  assign mem_addr  = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign count     = r_count;

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          RdEn = 1'b0;
  logic          mem_ready = 1'b0;
  logic          Stall, FwdHit, mem_valid;
  logic [DW-1:0] FwdData, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [$clog2(DEPTH):0] count;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .RdEn(RdEn), .Stall(Stall), .FwdHit(FwdHit),
    .FwdData(FwdData), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic [AW-1:0] drained[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of {addr,data}; pops from the front, pushes at the back.
  always @(posedge clk or posedge reset) begin
    if (reset) q.delete();
    else begin
      int sz;
      sz = q.size();
      if (sz > 0 && mem_ready) void'(q.pop_front());
      if (MemWrite && sz < DEPTH) q.push_back('{DataAdr, WriteData});
    end
  end

  function automatic void model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (RdEn) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a[AW-1:2] == a[AW-1:2]) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
      end
    end
  endfunction

  // Compare process: every negedge, all outputs against the queue model.
  always @(negedge clk) begin
    logic          eh;
    logic [DW-1:0] ed;
    model_fwd(DataAdr, eh, ed);
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    chk("Stall", 64'(Stall), 64'(MemWrite && q.size() == DEPTH));
    chk("FwdHit", 64'(FwdHit), 64'(eh));
    chk("FwdData", 64'(FwdData), 64'(ed));
    if (q.size() != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
      if (mem_ready) drained.push_back(mem_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic rd, input logic rdy);
    MemWrite  = mw;
    DataAdr   = a;
    WriteData = wd;
    RdEn      = rd;
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    int pushed;
    // Reset held with a store pending
    set(1'b1, 32'h100, 32'hAA, 1'b1, 1'b0);
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_fwd", 64'(FwdHit), 64'd0);
    reset = 1'b0;
    step();
    chk("first_count", 64'(count), 64'd1);
    chk("first_addr", 64'(mem_addr), 64'h100);
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("first_drained", 64'(count), 64'd0);

    // Single store
    set(1'b1, 32'h64, 32'h7, 1'b0, 1'b1);
    chk("single_no_bypass", 64'(mem_valid), 64'd0);
    step();
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("single_valid", 64'(mem_valid), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h64);
    chk("single_data", 64'(mem_wdata), 64'h7);
    step();
    chk("single_count", 64'(count), 64'd0);
    chk("single_empty", 64'(mem_valid), 64'd0);

    // Fill and stall
    for (int k = 0; k < 4; k++) begin
      set(1'b1, 32'(4 * k), 32'(k + 1), 1'b0, 1'b0);
      step();
    end
    chk("full_count", 64'(count), 64'd4);
    set(1'b1, 32'h10, 32'h5, 1'b0, 1'b0);
    chk("full_stall", 64'(Stall), 64'd1);
    step();
    chk("stall_hold", 64'(count), 64'd4);
    set(1'b1, 32'h10, 32'h5, 1'b0, 1'b1);
    step();
    chk("pop_count", 64'(count), 64'd3);
    chk("pop_stall", 64'(Stall), 64'd0);
    chk("pop_head", 64'(mem_addr), 64'h4);
    set(1'b1, 32'h10, 32'h5, 1'b0, 1'b0);
    step();
    chk("refill", 64'(count), 64'd4);
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_addr", 64'(mem_addr), 64'(4 * k));
      chk("drain_data", 64'(mem_wdata), 64'(k + 1));
      step();
    end
    chk("drain_empty", 64'(mem_valid), 64'd0);

    // Forwarding
    set(1'b1, 32'h20, 32'h11, 1'b0, 1'b0); step();
    set(1'b1, 32'h20, 32'h22, 1'b0, 1'b0); step();
    set(1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    chk("fwd20_hit", 64'(FwdHit), 64'd1);
    chk("fwd20_data", 64'(FwdData), 64'h22);
    set(1'b0, 32'h23, 32'h0, 1'b1, 1'b0);
    chk("fwd23_hit", 64'(FwdHit), 64'd1);
    chk("fwd23_data", 64'(FwdData), 64'h22);
    set(1'b0, 32'h24, 32'h0, 1'b1, 1'b0);
    chk("fwd24_hit", 64'(FwdHit), 64'd0);
    chk("fwd24_data", 64'(FwdData), 64'd0);
    set(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    chk("fwd_rden0", 64'(FwdHit), 64'd0);
    set(1'b1, 32'h40, 32'h33, 1'b1, 1'b0);
    chk("fwd_push_invisible", 64'(FwdHit), 64'd0);
    step();
    set(1'b0, 32'h40, 32'h0, 1'b1, 1'b0);
    chk("fwd_push_visible", 64'(FwdData), 64'h33);
    set(1'b0, 32'h20, 32'h0, 1'b1, 1'b1);
    step();
    chk("fwd_old_popped", 64'(FwdData), 64'h22);
    step();
    chk("fwd_all_popped", 64'(FwdHit), 64'd0);
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(); step();

    // Concurrent push/pop at count=2
    set(1'b1, 32'h50, 32'h1, 1'b0, 1'b0); step();
    set(1'b1, 32'h54, 32'h2, 1'b0, 1'b0); step();
    set(1'b1, 32'h58, 32'h3, 1'b0, 1'b1); step();
    chk("concur_count", 64'(count), 64'd2);
    chk("concur_head", 64'(mem_addr), 64'h54);
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(); step();

    // Stream 10 stores with mem_ready toggling
    drained.delete();
    pushed = 0;
    for (int cyc = 0; cyc < 100 && (pushed < 10 || q.size() != 0); cyc++) begin
      if (pushed < 10)
        set(1'b1, 32'h200 + 32'(4 * pushed), 32'hD0 + 32'(pushed), 1'b0, cyc[0]);
      else
        set(1'b0, 32'h0, 32'h0, 1'b0, cyc[0]);
      if (pushed < 10 && q.size() < DEPTH) pushed++;
      step();
    end
    chk("stream_pushed", 64'(pushed), 64'd10);
    chk("stream_ndrained", 64'(drained.size()), 64'd10);
    for (int k = 0; k < 10 && k < drained.size(); k++)
      chk("stream_order", 64'(drained[k]), 64'(32'h200 + 32'(4 * k)));

    // Async reset mid-drain
    for (int k = 0; k < 3; k++) begin
      set(1'b1, 32'h300 + 32'(4 * k), 32'(k), 1'b0, 1'b0);
      step();
    end
    set(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    chk("pre_rst_valid", 64'(mem_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(mem_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    step();
    reset = 1'b0;
    step(); step();
    chk("post_rst_idle", 64'(mem_valid), 64'd0);

    // Random traffic; a stalled store is held stable until accepted
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [AW-1:0] a;
      logic stalled;
      stalled = MemWrite && (q.size() == DEPTH);
      a = {24'h0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31) & 5'h1F)};
      a[4:2] = 3'($urandom_range(0, 3));
      if (stalled)
        set(MemWrite, DataAdr, WriteData, RdEn, 1'($urandom_range(0, 2) == 0));
      else if ($urandom_range(0, 1) == 1)
        set(1'b1, a, $urandom, 1'b0, 1'($urandom_range(0, 2) != 0));
      else
        set(1'b0, a, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-store buffer between the pipelined processor's data-memory port (MemWrite, DataAdr, WriteData) and a slower data memory that uses a valid/ready handshake.
- Accepts processor stores in one cycle and drains them to memory in FIFO order.
- Stalls the processor only when full.
- Forwards the youngest buffered store data to processor loads whose address matches a pending entry, so loads never return stale memory data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- MemWrite  in  1  processor store strobe, sampled on the rising clk edge.
- DataAdr  in  AW  processor byte address for the store or load.
- WriteData  in  DW  processor store data.
- RdEn  in  1  processor load is using DataAdr this cycle.
- Stall  out  1  combinational: MemWrite && full; the processor holds MemWrite, DataAdr and WriteData stable while it is high.
- FwdHit  out  1  combinational: the load address matches a buffered entry.
- FwdData  out  DW  combinational: data of the youngest matching entry; 0 when FwdHit=0.
- mem_valid  out  1  head entry present toward memory.
- mem_addr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  memory accepts the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: circular array of DEPTH {addr, data} entries, head pointer, tail pointer and count. Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0).
- Push: MemWrite && !full at a clk edge writes {DataAdr, WriteData} at tail, advances tail, and increments count.
  - MemWrite while full: nothing is written, Stall=1.
  - Space freed by a pop becomes usable at the following edge; there is no same-cycle push into a full buffer.
- Pop: mem_valid && mem_ready at a clk edge advances head and decrements count.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Drain interface:
  - mem_valid = !empty.
  - mem_addr and mem_wdata come from the head entry and stay stable while mem_valid && !mem_ready.
  - Entries are issued strictly in push order.
- Latency: a store pushed into an empty buffer appears on mem_valid/mem_addr/mem_wdata the cycle after acceptance. There is no combinational bypass from processor to memory.
- Forwarding:
  - When RdEn=1, DataAdr[AW-1:2] is compared against addr[AW-1:2] of every valid entry; DataAdr[1:0] is ignored.
  - On any match: FwdHit=1 and FwdData = data of the match closest to tail (youngest).
  - An entry being popped in the current cycle still counts as a match.
  - A store being pushed in the current cycle is not visible until the next cycle.
  - RdEn=0 forces FwdHit=0 and FwdData=0.
- Addresses are stored unaltered, including bits [1:0].
- Reset:
  - On assertion: count=0, head=tail=0, mem_valid=0, FwdHit=0, FwdData=0, Stall=0. Entry contents are don't-care.
  - Assertion mid-operation discards all pending stores, including one currently presented to memory.
  - On deassertion, operation resumes at the next clk edge.
- count never exceeds DEPTH and never underflows. A pop while empty is impossible because mem_valid=0.

Test Plan:
- Reset: hold reset 2 cycles while MemWrite=1 → count=0, mem_valid=0, Stall=0, FwdHit=0 throughout; first store accepted at the first edge after release.
- Single store: mem_ready=1, store addr 0x64 data 0x7 → next cycle mem_valid=1, mem_addr=0x64, mem_wdata=0x7; popped at that edge; count returns to 0 and mem_valid=0.
- Full/stall: mem_ready=0, stores to 0x0,0x4,0x8,0xC,0x10 (data 1..5) → count=4 after the 4th and Stall=1 on the 5th. Pulse mem_ready for one cycle → 0x0 drained, 0x10 accepted at the next edge, Stall=0. Drain order is then 0x4,0x8,0xC,0x10.
- Forwarding: with mem_ready=0, store 0x20←0x11 then 0x20←0x22. Then:
  - RdEn at 0x20 → FwdHit=1, FwdData=0x22.
  - RdEn at 0x23 → FwdHit=1, FwdData=0x22.
  - RdEn at 0x24 → FwdHit=0, FwdData=0.
  - RdEn=0 at 0x20 → FwdHit=0.
- Concurrency/wrap: with count=2, push and pop on the same edge → count stays 2. Stream 10 stores with mem_ready toggling every cycle → all 10 emerge in order with correct data across pointer wrap.
- Async reset mid-drain: count=3, mem_valid=1; assert reset between clock edges → mem_valid=0 and count=0 immediately, before the next edge; no further mem_valid until a new store.
